// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunk-serial adder/subtractor.
// No logic; enum and operation/mode encodings only.
// Not applicable (package).
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam logic MODE_TWOS = 1'b0;
    localparam logic MODE_ONES = 1'b1;

endpackage

// File: rtl/addsub_serial_chunk_adder.sv
// Combinational ripple-carry adder over one CHUNK-bit slice.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the owner decides when results are captured.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    // Ripple the carry bit by bit; the carry entering the top bit is exported for overflow detection.
    always_comb begin : ripple
        logic w_c;
        w_c      = cin;
        c_msb_in = cin;
        sum      = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = w_c;
            end
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (a[i] & w_c) | (b[i] & w_c);
        end
        cout = w_c;
    end

endmodule

// File: rtl/addsub_serial.sv
// Chunk-serial add/sub, two's or one's complement (one's adds an end-around-carry pass).
// Latency: WIDTH/CHUNK cycles from accept to out_valid, twice that when the EAC pass runs.
// Backpressure: result and flags hold in DONE until out_ready; in_ready only in IDLE.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    import addsub_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
            $error("addsub_serial: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_mode;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_result;
    logic              r_carry_out;
    logic              r_overflow;
    logic              r_zero;
    logic              r_out_valid;

    logic [CHUNK-1:0]  w_add_a;
    logic [CHUNK-1:0]  w_add_b;
    logic [CHUNK-1:0]  w_sum;
    logic              w_cout;
    logic              w_c_msb_in;
    logic              w_last;
    logic [WIDTH-1:0]  w_result_nxt;
    logic              w_zero_nxt;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a        (w_add_a),
        .b        (w_add_b),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Pick the current chunk: operands in RUN, partial result plus zero in EAC.
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_add_a = (r_state == EAC) ? r_result[i*CHUNK +: CHUNK] : r_a[i*CHUNK +: CHUNK];
                w_add_b = (r_state == EAC) ? '0 : r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // Splice the adder output into the indexed chunk of the result.
    always_comb begin
        w_result_nxt = r_result;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_result_nxt[i*CHUNK +: CHUNK] = w_sum;
            end
        end
    end

    assign w_last     = (r_idx == LAST_IDX);
    assign w_zero_nxt = (w_result_nxt == '0) ||
                        ((r_mode == MODE_ONES) && (w_result_nxt == {WIDTH{1'b1}}));

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = RUN;
            RUN:  if (w_last) w_state_nxt = (r_mode == MODE_ONES && w_cout) ? EAC : DONE;
            EAC:  if (w_last) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, serial accumulation and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= MODE_TWOS;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= (op == OP_SUB) ? ~b : b;
                        r_mode  <= mode;
                        r_carry <= (op == OP_SUB) && (mode == MODE_TWOS);
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_result <= w_result_nxt;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_carry_out <= w_cout;
                        r_overflow  <= w_c_msb_in ^ w_cout;
                        r_idx       <= '0;
                        if (r_mode == MODE_ONES && w_cout) begin
                            // End-around carry: re-add the carry starting from chunk 0.
                            r_carry <= 1'b1;
                        end else begin
                            r_zero      <= w_zero_nxt;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                EAC: begin
                    r_result <= w_result_nxt;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_idx       <= '0;
                        r_zero      <= w_zero_nxt;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial (WIDTH=16, CHUNK=4).
// Expected results come from a plain-arithmetic model, popped by a monitor on each out handshake.
// Covers directed corner cases, backpressure, mid-operation reset and random traffic.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        op_i = 1'b0;
    logic        mode_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          rdy_mode = 0;
    logic        prev_ov = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [15:0] prev_res = '0;
    logic [2:0]  prev_flags = '0;

    addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .op        (op_i),
        .mode      (mode_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream readiness: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference: wide arithmetic on integers, one's complement folds the carry back in.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mop, input logic mmode);
        exp_t        e;
        logic [15:0] be;
        logic [16:0] full;
        logic        cin;
        int          s;
        be   = mop ? ~mb : mb;
        cin  = mop && !mmode;
        full = 17'(ma) + 17'(be) + 17'(cin);
        if (!mmode) begin
            s = mop ? (int'($signed(ma)) - int'($signed(mb))) : (int'($signed(ma)) + int'($signed(mb)));
        end else begin
            s = int'($signed(ma)) + int'($signed(be));
        end
        e.co  = full[16];
        e.ov  = (s > 32767) || (s < -32768);
        e.res = mmode ? (full[15:0] + 16'(full[16])) : full[15:0];
        e.z   = (e.res == 16'h0000) || (mmode && e.res == 16'hFFFF);
        e.lat = (mmode && full[16]) ? 8 : 4;
        e.acc = 0;
        return e;
    endfunction

    // Present one operation (called at a falling edge) and push its expectation on acceptance.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic top,
                        input logic tmode, input bit keep, output int acc);
        exp_t e;
        bit   ok;
        ok       = 1'b0;
        a_i      = ta;
        b_i      = tb;
        op_i     = top;
        mode_i   = tmode;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            acc = -1;
        end else begin
            e     = model(ta, tb, top, tmode);
            e.acc = cyc + 1;
            acc   = e.acc;
            q.push_back(e);
            @(negedge clk);
            if (!keep) in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            fail_now("drain_timeout");
            q.delete();
        end
    endtask

    // Monitor: latency on out_valid rise, stability under stall, scoreboard compare on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov  = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (q.size() == 0) fail_now("unexpected_out_valid");
                    else chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                end
                if (out_valid && prev_ov && !prev_rdy) begin
                    chk("hold_result", 32'(result), 32'(prev_res));
                    chk("hold_flags", 32'({carry_out, overflow, zero}), 32'(prev_flags));
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        mon_e = q.pop_front();
                        chk("result", 32'(result), 32'(mon_e.res));
                        chk("carry_out", 32'(carry_out), 32'(mon_e.co));
                        chk("overflow", 32'(overflow), 32'(mon_e.ov));
                        chk("zero", 32'(zero), 32'(mon_e.z));
                        last_hs = cyc + 1;
                    end
                end
                prev_ov    = out_valid;
                prev_rdy   = out_ready;
                prev_res   = result;
                prev_flags = {carry_out, overflow, zero};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          acc2;
        bit          seen;
        logic [15:0] edges [4];
        logic [15:0] ra;
        logic [15:0] rb;
        edges[0] = 16'h0000;
        edges[1] = 16'hFFFF;
        edges[2] = 16'h8000;
        edges[3] = 16'h7FFF;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({carry_out, overflow, zero}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases.
        send(16'h0007, 16'h0003, 1'b1, 1'b0, 1'b0, acc); drain();
        send(16'h0007, 16'h0003, 1'b1, 1'b1, 1'b0, acc); drain();
        send(16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0, acc); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, acc); drain();

        // Backpressure with the next operand already waiting.
        rdy_mode = 2;
        send(16'h1234, 16'h0FF0, 1'b0, 1'b0, 1'b1, acc);
        fork
            send(16'h00F0, 16'h0100, 1'b1, 1'b1, 1'b0, acc2);
            begin
                seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) fail_now("bp_out_valid_timeout");
                repeat (4) @(negedge clk);
                rdy_mode = 0;
            end
        join
        chk("accept_after_handshake", 32'(acc2 - last_hs), 32'd1);
        drain();

        // Reset during the second RUN cycle.
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_flags", 32'({carry_out, overflow, zero}), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(16'h0100, 16'h00FF, 1'b1, 1'b1, 1'b0, acc); drain();

        // Random traffic with random downstream stalls.
        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, acc);
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
